// File: rtl/pipeline_pkg.sv
// Shared types for generic pipeline-boundary registers: occupancy states and
// per-boundary payload layouts.
package pipeline_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instruction;
    logic [PC_W-1:0]    pc_plus_four;
  } fd_payload_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for per-stage statistics; sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_stage_register.sv
// Generic valid/ready inter-stage register with a 2-entry skid buffer, flush
// bubble insertion and registered in_ready. Optional stats via STAGE_STATS_EN.
module pipeline_stage_register
  import pipeline_pkg::*;
#(
  parameter int DATA_W     = $bits(fd_payload_t),
  parameter bit CLEAR_DATA = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef STAGE_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
`endif
);

  stage_state_t      state_p0;
  stage_state_t      state_nxt;
  logic              rdy_p0;
  logic [DATA_W-1:0] main_p0;
  logic [DATA_W-1:0] skid_p0;

  logic in_fire;
  logic out_fire;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;

  // in_ready depends only on a register and reset, never on out_ready.
  assign in_ready  = rdy_p0 & ~reset;
  assign out_valid = (state_p0 != ST_EMPTY);
  assign out_data  = main_p0;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_nxt      = state_p0;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_p0)
      ST_EMPTY: begin
        if (in_fire) begin
          state_nxt    = ST_ONE;
          load_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          load_main_in = 1'b1;
        end else if (in_fire) begin
          state_nxt = ST_FULL;
          load_skid = 1'b1;
        end else if (out_fire) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          state_nxt      = ST_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  // ---- control stage: occupancy and registered ready ----
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state_p0 <= ST_EMPTY;
      rdy_p0   <= 1'b1;
    end else begin
      state_p0 <= state_nxt;
      rdy_p0   <= (state_nxt != ST_FULL);
    end
  end

  // ---- data stage: written only on accepted input or skid->main move ----
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      if (CLEAR_DATA) begin
        main_p0 <= '0;
        skid_p0 <= '0;
      end
    end else begin
      if (load_main_in) begin
        main_p0 <= in_data;
      end else if (load_main_skid) begin
        main_p0 <= skid_p0;
      end
      if (load_skid) begin
        skid_p0 <= in_data;
      end
    end
  end

`ifdef STAGE_STATS_EN
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (out_valid & ~out_ready & ~flush),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush),
    .count (flush_count)
  );
`else
  logic [CNT_W-1:0] unused_cnt;
  assign unused_cnt = '0;
`endif

endmodule
